tbb_fetch_arb: RTL and testbench

TBB_FETCH_ARB -- requirements
Module: tbb_fetch_arb

---
 rtl/tbb_fetch_arb.sv | 149 ++++++++++++++
 tb/tb_tbb_fetch_arb.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbb_fetch_arb.sv
// Task batch buffer fetch arbiter: round-robin grants from NUM_TBB buffers
// into a single memory read slot, tracks reads in flight, and steers
// out-of-order read responses back into the owning buffer.

// Per-buffer write strobe: fires one cycle after a response for this buffer.
module tbb_fetch_arb_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rsp_valid,
  input  logic [IDX_W-1:0] rsp_idx,
  output logic             wr_en
);

  // Register the decoded strobe; an index with no matching lane writes nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_en <= 1'b0;
    else       wr_en <= rsp_valid && (rsp_idx == IDX_W'(LANE));
  end

endmodule

module tbb_fetch_arb #(
  parameter  int NUM_TBB = 4,
  parameter  int LINE_W  = 12,
  parameter  int DATA_W  = 512,
  parameter  int ADDR_W  = 32,
  parameter  int MAX_OUT = 32,
  localparam int IDX_W   = $clog2(NUM_TBB),
  localparam int TAG_W   = IDX_W + LINE_W,
  localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic                      cfg_valid,
  input  logic [NUM_TBB-1:0]        tbb_req_valid,
  input  logic [NUM_TBB*LINE_W-1:0] tbb_req_line,
  output logic [NUM_TBB-1:0]        tbb_req_ack,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [ADDR_W-1:0]         rd_req_addr,
  output logic [TAG_W-1:0]          rd_req_tag,
  input  logic                      rd_rsp_valid,
  input  logic [TAG_W-1:0]          rd_rsp_tag,
  input  logic [DATA_W-1:0]         rd_rsp_data,
  output logic [NUM_TBB-1:0]        tbb_wr_en,
  output logic [LINE_W-1:0]         tbb_wr_addr,
  output logic [DATA_W-1:0]         tbb_wr_din,
  output logic [OUT_W-1:0]          outstanding,
  output logic                      err_underflow
);

  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUT);

  logic [NUM_TBB-1:0][LINE_W-1:0] req_line;
  logic [IDX_W-1:0]               rr_ptr, gnt_idx, cand, rr_nxt;
  logic                           any_req, slot_free, gnt, rsp_dec;
  logic [ADDR_W-1:0]              gnt_addr;
  logic [TAG_W-1:0]               gnt_tag;
  logic [IDX_W-1:0]               rsp_idx;

  assign req_line  = tbb_req_line;
  assign slot_free = !rd_req_valid || rd_req_ready;
  assign gnt       = !reset && slot_free && cfg_valid && (outstanding < MAX_CNT) && any_req;
  assign gnt_addr  = cfg_base_addr + (ADDR_W'(gnt_idx) << LINE_W) + ADDR_W'(req_line[gnt_idx]);
  assign gnt_tag   = {gnt_idx, req_line[gnt_idx]};
  assign rr_nxt    = IDX_W'((int'(gnt_idx) + 1) % NUM_TBB);
  assign rsp_dec   = rd_rsp_valid && (outstanding != '0);
  assign rsp_idx   = rd_rsp_tag[TAG_W-1:LINE_W];

  // Round-robin search: first requesting buffer at or after rr_ptr, wrapping.
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_TBB; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_TBB);
      if (!any_req && tbb_req_valid[cand]) begin
        any_req = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot grant pulse in the grant cycle itself.
  always_comb begin
    tbb_req_ack = '0;
    if (gnt) tbb_req_ack[gnt_idx] = 1'b1;
  end

  // Issue slot: reload on grant (also in the acceptance cycle), else empty on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_tag   <= '0;
    end else if (gnt) begin
      rd_req_valid <= 1'b1;
      rd_req_addr  <= gnt_addr;
      rd_req_tag   <= gnt_tag;
    end else if (rd_req_ready) begin
      rd_req_valid <= 1'b0;
    end
  end

  // Pointer moves past the granted buffer only when a grant happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    rr_ptr <= '0;
    else if (gnt) rr_ptr <= rr_nxt;
  end

  // In-flight counter; a response with nothing in flight cannot decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 outstanding <= '0;
    else if (gnt && !rsp_dec)  outstanding <= outstanding + 1'b1;
    else if (!gnt && rsp_dec)  outstanding <= outstanding - 1'b1;
  end

  // Sticky flag for a response that arrives with no read outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    err_underflow <= 1'b0;
    else if (rd_rsp_valid && outstanding == '0)   err_underflow <= 1'b1;
  end

  // Shared write address/data follow the latest response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbb_wr_addr <= '0;
      tbb_wr_din  <= '0;
    end else if (rd_rsp_valid) begin
      tbb_wr_addr <= rd_rsp_tag[LINE_W-1:0];
      tbb_wr_din  <= rd_rsp_data;
    end
  end

  for (genvar i = 0; i < NUM_TBB; i++) begin : g_lane
    tbb_fetch_arb_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .rsp_valid(rd_rsp_valid),
      .rsp_idx  (rsp_idx),
      .wr_en    (tbb_wr_en[i])
    );
  end

endmodule

// File: tb/tb_tbb_fetch_arb.sv
// Bench for tbb_fetch_arb: directed scenarios plus a randomized run, all
// checked against a transaction-level model of grants, slot and counters.
module tb_tbb_fetch_arb;

  localparam int NT = 4, LW = 12, DW = 64, AW = 32, MO = 4;
  localparam int TW = 14, OW = 3, LV = NT * LW;

  logic          clk, reset;
  logic [AW-1:0] cfg_base_addr;
  logic          cfg_valid;
  logic [NT-1:0] tbb_req_valid, tbb_req_ack;
  logic [LV-1:0] tbb_req_line;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [TW-1:0] rd_req_tag, rd_rsp_tag;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data, tbb_wr_din;
  logic [NT-1:0] tbb_wr_en;
  logic [LW-1:0] tbb_wr_addr;
  logic [OW-1:0] outstanding;
  logic          err_underflow;

  tbb_fetch_arb #(.NUM_TBB(NT), .LINE_W(LW), .DATA_W(DW), .ADDR_W(AW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset), .cfg_base_addr(cfg_base_addr), .cfg_valid(cfg_valid),
    .tbb_req_valid(tbb_req_valid), .tbb_req_line(tbb_req_line), .tbb_req_ack(tbb_req_ack),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_tag(rd_req_tag), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tag(rd_rsp_tag),
    .rd_rsp_data(rd_rsp_data), .tbb_wr_en(tbb_wr_en), .tbb_wr_addr(tbb_wr_addr),
    .tbb_wr_din(tbb_wr_din), .outstanding(outstanding), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int            m_rr, m_out;
  bit            m_vld, m_err;
  logic [AW-1:0] m_addr;
  logic [TW-1:0] m_tag;
  logic [NT-1:0] m_wr_en;
  logic [LW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_din;
  logic [TW-1:0] inflight[$];
  int            errors, checks;

  function automatic logic [LW-1:0] line_of(int i);
    logic [LV-1:0] v;
    v = tbb_req_line;
    return v[i*LW +: LW];
  endfunction

  // Which buffer should win this cycle, or -1.
  function automatic int model_gnt();
    if (reset) return -1;
    if (m_vld && !rd_req_ready) return -1;
    if (!cfg_valid || m_out >= MO) return -1;
    for (int k = 0; k < NT; k++)
      if (tbb_req_valid[(m_rr + k) % NT]) return (m_rr + k) % NT;
    return -1;
  endfunction

  function automatic logic [NT-1:0] oh(int g);
    logic [NT-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int ack_idx();
    int r;
    r = -1;
    for (int i = 0; i < NT; i++) if (tbb_req_ack[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_out = 0; m_vld = 0; m_err = 0; m_addr = '0; m_tag = '0;
    m_wr_en = '0; m_wr_addr = '0; m_wr_din = '0;
    inflight.delete();
  endtask

  // Advance one clock, applying the cycle's inputs to the model.
  task automatic tick();
    int g, pre, idx;
    g = model_gnt();
    @(posedge clk);
    pre = m_out;
    if (g >= 0) begin
      m_vld  = 1;
      m_tag  = TW'((g << LW) + int'(line_of(g)));
      m_addr = AW'(longint'(cfg_base_addr) + longint'(g) * 4096 + longint'(line_of(g)));
      m_rr   = (g + 1) % NT;
      inflight.push_back(m_tag);
    end else if (rd_req_ready) m_vld = 0;
    if (rd_rsp_valid) begin
      if (pre == 0) m_err = 1;
      idx       = int'(rd_rsp_tag) >> LW;
      m_wr_en   = (idx < NT) ? oh(idx) : '0;
      m_wr_addr = rd_rsp_tag[LW-1:0];
      m_wr_din  = rd_rsp_data;
    end else m_wr_en = '0;
    m_out = pre + ((g >= 0) ? 1 : 0) - ((rd_rsp_valid && pre > 0) ? 1 : 0);
    #1;
  endtask

  task automatic drive_rsp(bit en);
    int j;
    if (en && inflight.size() > 0) begin
      j = $urandom_range(0, inflight.size() - 1);
      rd_rsp_tag   = inflight[j];
      inflight.delete(j);
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = {$urandom, $urandom};
    end else rd_rsp_valid = 1'b0;
  endtask

  task automatic drain();
    tbb_req_valid = '0;
    rd_req_ready  = 1'b1;
    while (inflight.size() > 0 || m_vld) begin
      drive_rsp(1);
      tick();
    end
    rd_rsp_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_valid = 1'b1; tbb_req_valid = '1; rd_req_ready = 1'b1;
    cfg_base_addr = 32'h1000; tbb_req_line = '0; rd_rsp_valid = 1'b0;
    rd_rsp_tag = '0; rd_rsp_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tbb_req_ack !== '0) begin errors++; $display("FAIL reset_ack: got %h want 0", tbb_req_ack); end
    checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b want 0", rd_req_valid); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_out: got %0d want 0", outstanding); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    checks++; if (tbb_wr_en !== '0) begin errors++; $display("FAIL reset_wren: got %h want 0", tbb_wr_en); end
    #2 reset = 1'b0;
    tbb_req_valid = '0;
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    cfg_base_addr = 32'h1000; tbb_req_line = '0; tbb_req_line[LW-1:0] = 12'd5;
    tbb_req_valid = 4'b0001; rd_req_ready = 1'b1; cfg_valid = 1'b1;
    #1;
    checks++; if (tbb_req_ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", tbb_req_ack); end
    tick();
    tbb_req_valid = '0;
    checks++; if (rd_req_valid !== 1'b1) begin errors++; $display("FAIL single_rdv: got %b want 1", rd_req_valid); end
    checks++; if (rd_req_addr !== 32'h1005) begin errors++; $display("FAIL single_addr: got %h want 00001005", rd_req_addr); end
    checks++; if (rd_req_tag !== 14'h005) begin errors++; $display("FAIL single_tag: got %h want 0005", rd_req_tag); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_out: got %0d want 1", outstanding); end
    d = {$urandom, $urandom};
    rd_rsp_valid = 1'b1; rd_rsp_tag = 14'h005; rd_rsp_data = d; inflight.delete();
    tick();
    rd_rsp_valid = 1'b0;
    checks++; if (tbb_wr_en !== 4'b0001 || tbb_wr_addr !== 12'd5 || tbb_wr_din !== d)
      begin errors++; $display("FAIL single_wr: got en=%b addr=%h din=%h want en=0001 addr=005 din=%h", tbb_wr_en, tbb_wr_addr, tbb_wr_din, d); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_out0: got %0d want 0", outstanding); end
  endtask

  task automatic test_round_robin();
    int prev, a;
    prev = -1;
    tbb_req_valid = '1; rd_req_ready = 1'b1; cfg_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tbb_req_line = LV'({$urandom, $urandom});
      drive_rsp(1);
      #1;
      a = ack_idx();
      checks++; if (tbb_req_ack !== oh(model_gnt())) begin errors++; $display("FAIL rr_ack: got %b want %b", tbb_req_ack, oh(model_gnt())); end
      checks++; if (a < 0 || (prev >= 0 && a != (prev + 1) % NT)) begin errors++; $display("FAIL rr_order: got %0d want %0d", a, (prev + 1) % NT); end
      prev = a;
      tick();
      checks++; if (rd_req_tag !== m_tag || rd_req_addr !== m_addr) begin errors++; $display("FAIL rr_req: got tag=%h addr=%h want tag=%h addr=%h", rd_req_tag, rd_req_addr, m_tag, m_addr); end
    end
    rd_rsp_valid = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] ht;
    logic [AW-1:0] ha;
    tbb_req_valid = '1; rd_req_ready = 1'b0; tbb_req_line = LV'({$urandom, $urandom});
    #1;
    checks++; if (!$onehot(tbb_req_ack) || tbb_req_ack !== oh(model_gnt())) begin errors++; $display("FAIL bp_first: got %b want %b", tbb_req_ack, oh(model_gnt())); end
    tick();
    ht = m_tag; ha = m_addr;
    for (int c = 0; c < 5; c++) begin
      tbb_req_line = LV'({$urandom, $urandom});
      #1;
      checks++; if (tbb_req_ack !== '0) begin errors++; $display("FAIL bp_noack: got %b want 0000", tbb_req_ack); end
      tick();
      checks++; if (rd_req_valid !== 1'b1 || rd_req_tag !== ht || rd_req_addr !== ha) begin errors++; $display("FAIL bp_hold: got v=%b tag=%h addr=%h want v=1 tag=%h addr=%h", rd_req_valid, rd_req_tag, rd_req_addr, ht, ha); end
    end
    rd_req_ready = 1'b1;
    #1;
    checks++; if (tbb_req_ack === '0 || tbb_req_ack !== oh(model_gnt())) begin errors++; $display("FAIL bp_accept_gnt: got %b want %b", tbb_req_ack, oh(model_gnt())); end
    tick();
    checks++; if (rd_req_valid !== 1'b1 || rd_req_tag !== m_tag) begin errors++; $display("FAIL bp_reload: got v=%b tag=%h want v=1 tag=%h", rd_req_valid, rd_req_tag, m_tag); end
    drain();
  endtask

  task automatic test_max_out();
    int n;
    n = 0;
    tbb_req_valid = '1; rd_req_ready = 1'b1; rd_rsp_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tbb_req_line = LV'({$urandom, $urandom});
      #1;
      if (tbb_req_ack !== '0) n++;
      checks++; if (tbb_req_ack !== oh(model_gnt())) begin errors++; $display("FAIL max_ack: got %b want %b", tbb_req_ack, oh(model_gnt())); end
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL max_grants: got %0d want 4", n); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL max_out: got %0d want 4", outstanding); end
    drive_rsp(1);
    #1;
    checks++; if (tbb_req_ack !== '0) begin errors++; $display("FAIL max_rsp_cycle: got %b want 0000", tbb_req_ack); end
    tick();
    rd_rsp_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (tbb_req_ack !== '0) n++;
      tick();
    end
    checks++; if (n != 1) begin errors++; $display("FAIL max_refill: got %0d want 1", n); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL max_out2: got %0d want 4", outstanding); end
    drain();
  endtask

  task automatic test_response();
    logic [DW-1:0] d;
    tbb_req_valid = 4'b0100; tbb_req_line = '0; tbb_req_line[2*LW +: LW] = 12'h0FF;
    #1;
    checks++; if (tbb_req_ack !== 4'b0100) begin errors++; $display("FAIL rsp_ack1: got %b want 0100", tbb_req_ack); end
    tick();
    d = {$urandom, $urandom};
    rd_rsp_valid = 1'b1; rd_rsp_tag = 14'h20FF; rd_rsp_data = d;
    void'(inflight.pop_front());
    #1;
    checks++; if (tbb_req_ack !== 4'b0100) begin errors++; $display("FAIL rsp_ack2: got %b want 0100", tbb_req_ack); end
    tick();
    rd_rsp_valid = 1'b0; tbb_req_valid = '0;
    checks++; if (tbb_wr_en !== 4'b0100 || tbb_wr_addr !== 12'h0FF || tbb_wr_din !== d)
      begin errors++; $display("FAIL rsp_wr: got en=%b addr=%h din=%h want en=0100 addr=0ff din=%h", tbb_wr_en, tbb_wr_addr, tbb_wr_din, d); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL rsp_same: got %0d want 1", outstanding); end
    tick();
    checks++; if (tbb_wr_en !== '0) begin errors++; $display("FAIL rsp_pulse: got %b want 0000", tbb_wr_en); end
    drain();
  endtask

  task automatic test_underflow();
    rd_rsp_valid = 1'b1; rd_rsp_tag = TW'((1 << LW) + $urandom_range(0, 4095)); rd_rsp_data = {$urandom, $urandom};
    tick();
    rd_rsp_valid = 1'b0;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", err_underflow); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL uf_out: got %0d want 0", outstanding); end
    repeat (3) tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tbb_req_valid = NT'($urandom);
      tbb_req_line  = LV'({$urandom, $urandom});
      rd_req_ready  = ($urandom_range(0, 9) < 7);
      cfg_valid     = ($urandom_range(0, 9) < 9);
      cfg_base_addr = $urandom;
      drive_rsp($urandom_range(0, 9) < 4);
      #1;
      checks++; if (tbb_req_ack !== oh(model_gnt())) begin errors++; $display("FAIL rnd_ack: cyc %0d got %b want %b", c, tbb_req_ack, oh(model_gnt())); end
      tick();
      checks++; if (rd_req_valid !== m_vld || (m_vld && (rd_req_addr !== m_addr || rd_req_tag !== m_tag)))
        begin errors++; $display("FAIL rnd_req: cyc %0d got v=%b addr=%h tag=%h want v=%b addr=%h tag=%h", c, rd_req_valid, rd_req_addr, rd_req_tag, m_vld, m_addr, m_tag); end
      checks++; if (outstanding !== OW'(m_out)) begin errors++; $display("FAIL rnd_out: cyc %0d got %0d want %0d", c, outstanding, m_out); end
      checks++; if (tbb_wr_en !== m_wr_en || (|m_wr_en && (tbb_wr_addr !== m_wr_addr || tbb_wr_din !== m_wr_din)))
        begin errors++; $display("FAIL rnd_wr: cyc %0d got en=%b addr=%h want en=%b addr=%h", c, tbb_wr_en, tbb_wr_addr, m_wr_en, m_wr_addr); end
      checks++; if (err_underflow !== m_err) begin errors++; $display("FAIL rnd_err: cyc %0d got %b want %b", c, err_underflow, m_err); end
    end
    cfg_valid = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    tbb_req_valid = '1; rd_req_ready = 1'b1; cfg_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tbb_req_line = LV'({$urandom, $urandom});
      drive_rsp(c == 2);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (tbb_req_ack !== '0) begin errors++; $display("FAIL mid_ack: got %b want 0000", tbb_req_ack); end
    checks++; if (rd_req_valid !== 1'b0 || rd_req_addr !== '0 || rd_req_tag !== '0)
      begin errors++; $display("FAIL mid_req: got v=%b addr=%h tag=%h want all 0", rd_req_valid, rd_req_addr, rd_req_tag); end
    checks++; if (tbb_wr_en !== '0 || tbb_wr_addr !== '0 || tbb_wr_din !== '0)
      begin errors++; $display("FAIL mid_wr: got en=%b addr=%h want all 0", tbb_wr_en, tbb_wr_addr); end
    checks++; if (outstanding !== '0 || err_underflow !== 1'b0)
      begin errors++; $display("FAIL mid_cnt: got out=%0d err=%b want 0 0", outstanding, err_underflow); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    tbb_req_valid = '0; rd_rsp_valid = 1'b1; rd_rsp_tag = 14'h0123; rd_rsp_data = {$urandom, $urandom};
    tick();
    rd_rsp_valid = 1'b0;
    checks++; if (err_underflow !== 1'b1 || outstanding !== '0)
      begin errors++; $display("FAIL mid_after: got err=%b out=%0d want 1 0", err_underflow, outstanding); end
  endtask

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_max_out();
    test_response();
    test_underflow();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
